// File: rtl/nsa_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

endpackage

// File: rtl/nsa_slice.sv
// Combinational 4-bit add slice with carry-in and carry-out.
// Ports: a, b (NIB_W-bit addends), cin; sum (NIB_W-bit), cout.
module nsa_slice
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  // 5-bit internal result {cout,sum}
  always_comb begin
    {cout, sum} = (NIB_W+1)'(a) + (NIB_W+1)'(b) + (NIB_W+1)'(cin);
  end

endmodule

// File: rtl/nibble_serial_add.sv
// Multi-word adder: accepts A, B, cin on a valid/ready handshake, adds one
// nibble per clock through a single time-shared nsa_slice (LSB first), and
// returns sum/carry-out on a second valid/ready handshake.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_cin;
//        out_valid/out_ready/out_sum/out_cout; busy (RUN or DONE);
//        out_ovf (signed overflow) only when NSA_OVF_EN is defined.
module nibble_serial_add
  import nsa_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*WORDS-1:0] in_a,
  input  logic [NIB_W*WORDS-1:0] in_b,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
`ifdef NSA_OVF_EN
  ,
  output logic                   out_ovf
`endif
);

  localparam int unsigned OP_W  = NIB_W * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  nsa_state_e        state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic [NIB_W-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cout;

  assign slice_a = a_q[NIB_W*idx_q +: NIB_W];
  assign slice_b = b_q[NIB_W*idx_q +: NIB_W];

  nsa_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d      = in_a;
          b_d      = in_b;
          carry_d  = in_cin;
          idx_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[NIB_W*idx_q +: NIB_W] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == IDX_W'(WORDS-1)) begin
          // Signed overflow: like-signed operands producing a differently signed sum
          ovf_d   = (a_q[OP_W-1] == b_q[OP_W-1]) && (slice_sum[NIB_W-1] != a_q[OP_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          result_d = '0;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          idx_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = result_q;
  assign out_cout  = carry_q;

`ifdef NSA_OVF_EN
  assign out_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add.sv
// Directed self-checking bench for nibble_serial_add (WORDS=4).
module tb_nibble_serial_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;
`ifdef NSA_OVF_EN
  logic        out_ovf;
`endif

  int nvec = 0;
  int nerr = 0;
  int lat;

  always #5 clk = ~clk;

  nibble_serial_add #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef NSA_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic cin);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
  endtask

  // Cycles from acceptance edge until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic cin, input logic [15:0] es, input logic ec);
    start(a, b, cin);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(out_sum), 32'(es));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);

    op("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    handshake();
    op("1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    handshake();
    op("ripple", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);
    handshake();

    // Stall in DONE with a second operand set already offered
    op("stall", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    start(16'h2000, 16'h0022, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_sum", 32'(out_sum), 32'h0100);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_hs_in_ready", 32'(in_ready), 32'd1);
    chk("stall_hs_busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("stall_accept_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("stall_second_latency", 32'(lat), 32'd4);
    chk("stall_second_sum", 32'(out_sum), 32'h2022);
    handshake();

    // New operands presented during RUN must be ignored
    start(16'h1111, 16'h2222, 1'b0);
    tick();
    start(16'h0F0F, 16'h0101, 1'b0);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("run_ignore_latency", 32'(lat), 32'd4);
    chk("run_ignore_sum", 32'(out_sum), 32'h3333);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("run_second_latency", 32'(lat), 32'd4);
    chk("run_second_sum", 32'(out_sum), 32'h1010);
    handshake();

    // Reset during the 2nd RUN cycle aborts the operation
    start(16'hAAAA, 16'h5555, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    chk("abort_out_cout", 32'(out_cout), 32'd0);
    op("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
    handshake();

`ifdef NSA_OVF_EN
    op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("ovf_pos_flag", 32'(out_ovf), 32'd1);
    handshake();
    op("ovf_mixed", 16'h8000, 16'h7FFF, 1'b0, 16'hFFFF, 1'b0);
    chk("ovf_mixed_flag", 32'(out_ovf), 32'd0);
    handshake();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
